nonce_result_scan: RTL and testbench
====================================

Name: nonce_result_scan

Overview:
- Downstream consumer of the parallel bitcoin hash stage; runs after that stage's done pulse.
- Reads the NUM_NONCES final H0 words the hash stage wrote to shared memory at result_addr. H0 for nonce i is at result_addr+i.
- Compares each word against a difficulty target and reports hit count, lowest hash and winning nonce.
- Optionally writes a two-word summary back to memory. Shares the single-port memory bus and clock scheme of the hash stage.

Parameters:
NUM_NONCES, 16, number of consecutive H0 words scanned (2..255)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin scan; sampled in IDLE only
- result_addr  input  16  base address of H0 word for nonce 0
- target  input  32  difficulty target; a hash hits when hash < target (unsigned)
- mem_clk  output  1  equals clk (continuous assign)
- mem_we  output  1  memory write enable
- mem_addr  output  16  memory address (registered)
- mem_write_data  output  32  memory write data (registered)
- mem_read_data  input  32  memory read data
- done  output  1  one-cycle completion pulse
- found  output  1  at least one hit in last scan
- hit_count  output  8  number of hits in last scan
- best_nonce  output  8  index of minimum H0 (lowest index on tie)
- best_hash  output  32  minimum H0 value seen

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE
  - mem_we=0, mem_addr=0, mem_write_data=0
  - done=0, found=0, hit_count=0, best_nonce=0, best_hash=32'hFFFFFFFF
- Memory timing:
  - An address registered on mem_addr at edge k is sampled by memory at edge k+1.
  - The data is consumed by this block at edge k+2.
  - Track in-flight reads with a 2-deep valid/index pipeline.
- States: IDLE, SCAN, DRAIN, WB0, WB1, FIN.
- IDLE:
  - done=0 except the FIN pulse cycle.
  - On start: latch target; clear found/hit_count/best_*; mem_addr<=result_addr; issue index 0; go SCAN.
- SCAN:
  - One new address per cycle: mem_addr<=mem_addr+1, indices 1..NUM_NONCES-1.
  - After the last address is issued, go DRAIN.
- Processing each returning word w with index i:
  - if w<target: hit_count++ and found<=1
  - if w<best_hash (strict): best_hash<=w, best_nonce<=i
- DRAIN: wait until the last word is consumed (edge start+NUM_NONCES+1), then go FIN (or WB0 if feature on).
- FIN:
  - done<=1 for exactly one cycle, then IDLE.
  - found/hit_count/best_* hold until the next accepted start.
- Latency without writeback: done high in the cycle following edge start+NUM_NONCES+2.
- Boundary conditions:
  - start while not IDLE: ignored.
  - start held high across FIN: new scan begins the cycle after done.
  - target=0: no hits possible; best_* still computed.
  - All words equal: best_nonce=0.
  - All words 32'hFFFFFFFF: best_hash stays FFFFFFFF and best_nonce=0.
  - Address wrap: mem_addr wraps modulo 2^16 with no error.
- reset_n asserted mid-scan: immediate return to reset values. mem_we must drop asynchronously, so no partial write survives.
- mem_we is 1 only in WB0/WB1; mem_read_data is ignored in those states.

Optional Feature:
NONCE_SCAN_WRITEBACK_EN
- Defined: after DRAIN, WB0 writes {found, 7'b0, hit_count, 8'b0, best_nonce} to result_addr+NUM_NONCES. WB1 then writes best_hash to result_addr+NUM_NONCES+1. mem_we=1 in both states. mem_we<=0 on entry to FIN, and done is delayed by 2 cycles.
- Undefined: WB0/WB1 not built; mem_we tied 0; mem_write_data held 0.

Test Plan:
- All 16 words 32'h80000000, target=32'h00001000 -> found=0, hit_count=0, best_hash=32'h80000000, best_nonce=0, done exactly 1 cycle at start+18.
- Words i*32'h01000000+5 (i=0..15) with word 9 overwritten to 32'h00000003, target=32'h00000010 -> hit_count=2 (nonces 0,9), best_nonce=9, best_hash=3.
- Duplicate minimum 32'h00000042 at nonces 4 and 11 -> best_nonce=4.
- start pulsed again mid-SCAN and reset_n dropped at cycle 7 -> second start ignored; after reset all outputs at reset values, mem_we=0; a fresh start then completes correctly.
- NONCE_SCAN_WRITEBACK_EN with 2 hits, best nonce 9 at result_addr=16'h0100 -> 32'h80020009 written to 16'h0110, best_hash to 16'h0111; no other writes; done at start+20.
- result_addr=16'hFFF8 -> reads 16'hFFF8..16'hFFFF then 16'h0000..16'h0007; results correct.

Source files
------------

// File: rtl/nonce_result_scan.sv
//==============================================================================
// Module   : nonce_result_scan
// Scans the hash stage's H0 results; reports hit count, min hash, best nonce.
// Optional summary writeback when NONCE_SCAN_WRITEBACK_EN is defined.
// Revision : 1.0
//==============================================================================
`default_nettype none

module nonce_result_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        done,
  output logic        found,
  output logic [7:0]  hit_count,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash
);

  localparam logic [7:0] c_last_idx = 8'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_WB0   = 3'd3,
    S_WB1   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_addr;
  logic [31:0] r_target;
  logic [7:0]  r_issue_idx;
  logic        r_vld0;
  logic        r_vld1;
  logic [7:0]  r_idx0;
  logic [7:0]  r_idx1;
  logic        r_done;
  logic        r_found;
  logic [7:0]  r_hit_count;
  logic [7:0]  r_best_nonce;
  logic [31:0] r_best_hash;

  logic        w_hit;
  logic        w_better;
  logic        w_last_consume;
  logic        w_found_nxt;
  logic [7:0]  w_hit_count_nxt;
  logic [7:0]  w_best_nonce_nxt;
  logic [31:0] w_best_hash_nxt;

  assign mem_clk    = clk;
  assign mem_addr   = r_addr;
  assign done       = r_done;
  assign found      = r_found;
  assign hit_count  = r_hit_count;
  assign best_nonce = r_best_nonce;
  assign best_hash  = r_best_hash;

  // r_vld1/r_idx1 describe the word present on mem_read_data this cycle
  assign w_hit            = r_vld1 && (mem_read_data < r_target);
  assign w_better         = r_vld1 && (mem_read_data < r_best_hash);
  assign w_last_consume   = r_vld1 && (r_idx1 == c_last_idx);
  assign w_found_nxt      = r_found | w_hit;
  assign w_hit_count_nxt  = r_hit_count + {7'd0, w_hit};
  assign w_best_hash_nxt  = w_better ? mem_read_data : r_best_hash;
  assign w_best_nonce_nxt = w_better ? r_idx1 : r_best_nonce;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SCAN;
      S_SCAN:  if (r_issue_idx == c_last_idx) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_last_consume) begin
`ifdef NONCE_SCAN_WRITEBACK_EN
          w_state_nxt = S_WB0;
`else
          w_state_nxt = S_FIN;
`endif
        end
      end
`ifdef NONCE_SCAN_WRITEBACK_EN
      S_WB0:   w_state_nxt = S_WB1;
      S_WB1:   w_state_nxt = S_FIN;
`endif
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= 16'd0;
      r_target     <= 32'd0;
      r_issue_idx  <= 8'd0;
      r_vld0       <= 1'b0;
      r_vld1       <= 1'b0;
      r_idx0       <= 8'd0;
      r_idx1       <= 8'd0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_hit_count  <= 8'd0;
      r_best_nonce <= 8'd0;
      r_best_hash  <= 32'hFFFF_FFFF;
    end else begin
      r_done <= (r_state == S_FIN);
      r_vld1 <= r_vld0;
      r_idx1 <= r_idx0;
      r_vld0 <= 1'b0;

      if (r_vld1) begin
        r_found      <= w_found_nxt;
        r_hit_count  <= w_hit_count_nxt;
        r_best_hash  <= w_best_hash_nxt;
        r_best_nonce <= w_best_nonce_nxt;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target     <= target;
            r_found      <= 1'b0;
            r_hit_count  <= 8'd0;
            r_best_nonce <= 8'd0;
            r_best_hash  <= 32'hFFFF_FFFF;
            r_addr       <= result_addr;
            r_vld0       <= 1'b1;
            r_idx0       <= 8'd0;
            r_issue_idx  <= 8'd1;
          end
        end
        S_SCAN: begin
          r_addr      <= r_addr + 16'd1;
          r_vld0      <= 1'b1;
          r_idx0      <= r_issue_idx;
          r_issue_idx <= r_issue_idx + 8'd1;
        end
`ifdef NONCE_SCAN_WRITEBACK_EN
        // mem_addr rests on the last read address, so the summary slots follow it
        S_DRAIN: if (w_last_consume) r_addr <= r_addr + 16'd1;
        S_WB0:   r_addr <= r_addr + 16'd1;
`endif
        default: ;
      endcase
    end
  end

`ifdef NONCE_SCAN_WRITEBACK_EN
  logic        r_we;
  logic [31:0] r_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        // last word is folded in on this same edge, so use the next-state stats
        S_DRAIN: begin
          if (w_last_consume) begin
            r_we    <= 1'b1;
            r_wdata <= {w_found_nxt, 7'd0, w_hit_count_nxt, 8'd0, w_best_nonce_nxt};
          end
        end
        S_WB0:   r_wdata <= r_best_hash;
        S_WB1:   r_we    <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_we         = r_we;
  assign mem_write_data = r_wdata;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nonce_result_scan.sv
//==============================================================================
// Module   : tb_nonce_result_scan
// Randomized self-checking bench for nonce_result_scan with a memory model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_nonce_result_scan;

  localparam int N = 16;
`ifdef NONCE_SCAN_WRITEBACK_EN
  localparam int LAT = N + 4;
`else
  localparam int LAT = N + 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] result_addr = 16'd0;
  logic [31:0] target = 32'd0;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'd0;
  logic        done;
  logic        found;
  logic [7:0]  hit_count;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] words [N];
  logic [15:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  logic        exp_found;
  logic [7:0]  exp_hits;
  logic [7:0]  exp_nonce;
  logic [31:0] exp_hash;

  nonce_result_scan #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .result_addr(result_addr),
    .target(target), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .done(done), .found(found), .hit_count(hit_count),
    .best_nonce(best_nonce), .best_hash(best_hash)
  );

  always #5 clk = ~clk;

  // synchronous single-port memory: address sampled on the edge, data valid after it
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_write_data;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_write_data);
    end
    mem_read_data <= mem[mem_addr];
  end

  task automatic model(input logic [31:0] tgt);
    int h;
    logic [31:0] m;
    h = 0;
    m = 32'hFFFF_FFFF;
    foreach (words[i]) begin
      if (words[i] < tgt) h++;
      if (words[i] < m) m = words[i];
    end
    exp_hash  = m;
    exp_hits  = 8'(h);
    exp_found = (h > 0);
    exp_nonce = 8'd0;
    for (int i = N - 1; i >= 0; i--)
      if (words[i] == m) exp_nonce = 8'(i);
  endtask

  task automatic load(input logic [15:0] base);
    for (int i = 0; i < N; i++) mem[16'(base + 16'(i))] = words[i];
  endtask

  task automatic scan_and_check(input string name, input logic [15:0] base,
                                input logic [31:0] tgt, input int repulse);
    int lat;
    model(tgt);
    load(base);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    result_addr = base;
    target = tgt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    target = ~tgt;
    lat = 0;
    for (int c = 1; c <= LAT + 10; c++) begin
      @(posedge clk);
      #1;
      if (c == repulse) start = 1'b1;
      if (c == repulse + 1) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
    n_cmp++;
    if (found !== exp_found) begin
      n_bad++;
      $display("FAIL %s found: got %b want %b", name, found, exp_found);
    end
    n_cmp++;
    if (hit_count !== exp_hits) begin
      n_bad++;
      $display("FAIL %s hit_count: got %0d want %0d", name, hit_count, exp_hits);
    end
    n_cmp++;
    if (best_nonce !== exp_nonce) begin
      n_bad++;
      $display("FAIL %s best_nonce: got %0d want %0d", name, best_nonce, exp_nonce);
    end
    n_cmp++;
    if (best_hash !== exp_hash) begin
      n_bad++;
      $display("FAIL %s best_hash: got %h want %h", name, best_hash, exp_hash);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: got %b want 0", name, done);
    end
`ifdef NONCE_SCAN_WRITEBACK_EN
    n_cmp++;
    if (wr_addr_q.size() != 2) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d want 2", name, wr_addr_q.size());
    end else begin
      n_cmp++;
      if (wr_addr_q[0] !== 16'(base + 16'(N)) || wr_data_q[0] !== {exp_found, 7'd0, exp_hits, 8'd0, exp_nonce}) begin
        n_bad++;
        $display("FAIL %s wb0: got %h@%h want %h@%h", name, wr_data_q[0], wr_addr_q[0],
                 {exp_found, 7'd0, exp_hits, 8'd0, exp_nonce}, 16'(base + 16'(N)));
      end
      n_cmp++;
      if (wr_addr_q[1] !== 16'(base + 16'(N + 1)) || wr_data_q[1] !== exp_hash) begin
        n_bad++;
        $display("FAIL %s wb1: got %h@%h want %h@%h", name, wr_data_q[1], wr_addr_q[1],
                 exp_hash, 16'(base + 16'(N + 1)));
      end
    end
`else
    n_cmp++;
    if (wr_addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d want 0", name, wr_addr_q.size());
    end
`endif
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if ({mem_we, mem_addr, mem_write_data, done, found, hit_count, best_nonce, best_hash} !==
        {1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0, 32'hFFFF_FFFF}) begin
      n_bad++;
      $display("FAIL %s reset_values: got we=%b addr=%h wd=%h done=%b found=%b hits=%0d nonce=%0d hash=%h want 0/0/0/0/0/0/0/ffffffff",
               name, mem_we, mem_addr, mem_write_data, done, found, hit_count, best_nonce, best_hash);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(posedge clk);
    #1 check_reset_values("held_reset");
    n_cmp++;
    if (mem_clk !== clk) begin
      n_bad++;
      $display("FAIL mem_clk: got %b want %b", mem_clk, clk);
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_directed();
    foreach (words[i]) words[i] = 32'h8000_0000;
    scan_and_check("all_equal", 16'h0200, 32'h0000_1000, 0);
    foreach (words[i]) words[i] = 32'(i) * 32'h0100_0000 + 32'd5;
    words[9] = 32'h0000_0003;
    scan_and_check("two_hits", 16'h0100, 32'h0000_0010, 0);
    foreach (words[i]) words[i] = 32'h0000_1000 + 32'(i);
    words[4] = 32'h0000_0042;
    words[11] = 32'h0000_0042;
    scan_and_check("dup_min", 16'h0300, 32'h0000_0100, 0);
    foreach (words[i]) words[i] = 32'hFFFF_FFFF;
    scan_and_check("all_ff", 16'h0400, 32'hFFFF_FFFF, 0);
    foreach (words[i]) words[i] = $urandom;
    scan_and_check("target_zero", 16'h0500, 32'd0, 0);
  endtask

  task automatic test_wrap();
    foreach (words[i]) words[i] = 32'h1000 + 32'(i * 7 % 16);
    words[13] = 32'h0000_0007;
    for (int a = 16'hFFE0; a < 16'hFFF8; a++) mem[a] = 32'd0;
    for (int a = 8; a < 40; a++) mem[a] = 32'd0;
    scan_and_check("addr_wrap", 16'hFFF8, 32'h0000_1004, 0);
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int k = 0; k < 6; k++) begin
      tgt = $urandom;
      foreach (words[i]) begin
        words[i] = $urandom;
        if ($urandom_range(0, 2) == 0) words[i] = words[i] >> $urandom_range(1, 31);
      end
      words[$urandom_range(0, N - 1)] = words[$urandom_range(0, N - 1)];
      scan_and_check("random", 16'($urandom_range(16'h0600, 16'hF000)), tgt, 0);
    end
  endtask

  task automatic test_start_ignored();
    foreach (words[i]) words[i] = $urandom >> 4;
    words[6] = 32'h0000_0001;
    scan_and_check("start_in_scan", 16'h0700, 32'h0100_0000, 3);
  endtask

  task automatic test_midscan_reset();
    foreach (words[i]) words[i] = 32'h0000_0100 - 32'(i);
    load(16'h0800);
    @(negedge clk);
    result_addr = 16'h0800;
    target = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midscan_reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_values("after_midscan_reset");
    foreach (words[i]) words[i] = $urandom;
    scan_and_check("fresh_after_reset", 16'h0900, 32'h4000_0000, 0);
  endtask

`ifdef NONCE_SCAN_WRITEBACK_EN
  task automatic test_wb_reset();
    int seen;
    foreach (words[i]) words[i] = $urandom;
    load(16'h0A00);
    wr_addr_q.delete();
    @(negedge clk);
    result_addr = 16'h0A00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      @(posedge clk);
      #1;
      if (mem_we) begin
        seen = 1;
        break;
      end
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (seen != 1 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_reset: got seen=%0d we=%b want seen=1 we=0", seen, mem_we);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL wb_reset_writes: got %0d want 0", wr_addr_q.size());
    end
  endtask
`endif

  task automatic test_back_to_back();
    int t1, t2;
    foreach (words[i]) words[i] = $urandom;
    model(32'h8000_0000);
    load(16'h0B00);
    @(negedge clk);
    result_addr = 16'h0B00;
    target = 32'h8000_0000;
    start = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 3 * LAT + 10; c++) begin
      @(posedge clk);
      #1;
      if (done && t1 < 0) t1 = c;
      else if (done) begin
        t2 = c;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t1 < 0 || t2 - t1 != LAT + 1) begin
      n_bad++;
      $display("FAIL back_to_back gap: got %0d want %0d", t2 - t1, LAT + 1);
    end
    n_cmp++;
    if (best_hash !== exp_hash || best_nonce !== exp_nonce || hit_count !== exp_hits) begin
      n_bad++;
      $display("FAIL back_to_back results: got %h/%0d/%0d want %h/%0d/%0d",
               best_hash, best_nonce, hit_count, exp_hash, exp_nonce, exp_hits);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 32'd0;
    test_reset();
    test_directed();
    test_wrap();
    test_random();
    test_start_ignored();
    test_midscan_reset();
`ifdef NONCE_SCAN_WRITEBACK_EN
    test_wb_reset();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
